// File: rtl/glb_pkg.sv
// Shared GLB definitions: bank geometry, data-type codes, allocation field layout.
// Imported by both the address generator and the GLB address decoder.
package glb_pkg;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  localparam int unsigned BANK_NUM   = 27;
  localparam int unsigned BANK_DEPTH = 512;
  localparam int unsigned BANK_W     = clogb2(BANK_NUM);
  localparam int unsigned ADDR_W     = clogb2(BANK_NUM * BANK_DEPTH);
  localparam int unsigned AccW       = ADDR_W + 1;
  localparam int unsigned AllocW     = 3 * BANK_W;

  typedef enum logic [1:0] {
    DtNone  = 2'd0,
    DtIfmap = 2'd1,
    DtPsum  = 2'd2,
    DtWght  = 2'd3
  } data_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StValid,
    StDone
  } gen_state_e;

  // Allocation is packed {ifmap_cnt, psum_cnt, wght_cnt}, ifmap in the top field.
  function automatic logic [AccW-1:0] region_limit(input logic [AllocW-1:0] alloc,
                                                  input logic [1:0]        dt);
    logic [BANK_W-1:0] cnt;
    case (dt)
      DtIfmap: cnt = alloc[3*BANK_W-1:2*BANK_W];
      DtPsum:  cnt = alloc[2*BANK_W-1:BANK_W];
      DtWght:  cnt = alloc[BANK_W-1:0];
      default: cnt = '0;
    endcase
    return AccW'(cnt) * AccW'(BANK_DEPTH);
  endfunction

  // Accumulator add whose out-of-range bit is sticky, so a later wrap cannot look legal.
  function automatic logic [AccW-1:0] acc_add(input logic [AccW-1:0]   acc,
                                             input logic [ADDR_W-1:0] step);
    logic [AccW-1:0] sum;
    sum = acc + {1'b0, step};
    return {sum[ADDR_W] | acc[ADDR_W], sum[ADDR_W-1:0]};
  endfunction

endpackage

// File: rtl/glb_addr_loop2d.sv
// Two nested trip counters with running address accumulators (no multipliers).
// o_next_addr / o_next_last describe the position that will be issued next.
module glb_addr_loop2d
  import glb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_inner_cnt,
  input  logic [ADDR_W-1:0] i_outer_cnt,
  input  logic [ADDR_W-1:0] i_inner_stride,
  input  logic [ADDR_W-1:0] i_outer_stride,
  output logic [ADDR_W:0]   o_next_addr,
  output logic              o_next_last
);

  localparam logic [ADDR_W-1:0] One = ADDR_W'(1);

  logic [ADDR_W-1:0] inner_cnt_q, inner_cnt_d, outer_cnt_q, outer_cnt_d;
  logic [ADDR_W-1:0] inner_stride_q, inner_stride_d, outer_stride_q, outer_stride_d;
  logic [ADDR_W-1:0] inner_idx_q, inner_idx_d, outer_idx_q, outer_idx_d;
  logic [ADDR_W:0]   row_base_q, row_base_d, cur_q, cur_d;
  logic              inner_wrap, outer_wrap;

  always_comb begin
    inner_wrap     = (inner_idx_q == inner_cnt_q - One);
    outer_wrap     = (outer_idx_q == outer_cnt_q - One);
    inner_cnt_d    = inner_cnt_q;
    outer_cnt_d    = outer_cnt_q;
    inner_stride_d = inner_stride_q;
    outer_stride_d = outer_stride_q;
    inner_idx_d    = inner_idx_q;
    outer_idx_d    = outer_idx_q;
    row_base_d     = row_base_q;
    cur_d          = cur_q;
    if (i_init) begin
      inner_cnt_d    = i_inner_cnt;
      outer_cnt_d    = i_outer_cnt;
      inner_stride_d = i_inner_stride;
      outer_stride_d = i_outer_stride;
      inner_idx_d    = '0;
      outer_idx_d    = '0;
      row_base_d     = {1'b0, i_base_addr};
      cur_d          = {1'b0, i_base_addr};
    end else if (i_advance) begin
      if (inner_wrap) begin
        inner_idx_d = '0;
        outer_idx_d = outer_idx_q + One;
        row_base_d  = acc_add(row_base_q, outer_stride_q);
        cur_d       = row_base_d;
      end else begin
        inner_idx_d = inner_idx_q + One;
        cur_d       = acc_add(cur_q, inner_stride_q);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      inner_cnt_q    <= '0;
      outer_cnt_q    <= '0;
      inner_stride_q <= '0;
      outer_stride_q <= '0;
      inner_idx_q    <= '0;
      outer_idx_q    <= '0;
      row_base_q     <= '0;
      cur_q          <= '0;
    end else begin
      inner_cnt_q    <= inner_cnt_d;
      outer_cnt_q    <= outer_cnt_d;
      inner_stride_q <= inner_stride_d;
      outer_stride_q <= outer_stride_d;
      inner_idx_q    <= inner_idx_d;
      outer_idx_q    <= outer_idx_d;
      row_base_q     <= row_base_d;
      cur_q          <= cur_d;
    end
  end

  assign o_next_addr = cur_q;
  assign o_next_last = inner_wrap & outer_wrap;

endmodule

// File: rtl/glb_addr_gen.sv
// Streams bounds-checked 2-D strided GLB addresses over valid/ready for one data type,
// ending each pattern with a one-cycle done pulse (plus sticky error on failure).
module glb_addr_gen
  import glb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AllocW-1:0] i_GLB_allocation,
  input  logic              i_start,
  input  logic [1:0]        i_data_type,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_inner_cnt,
  input  logic [ADDR_W-1:0] i_outer_cnt,
  input  logic [ADDR_W-1:0] i_inner_stride,
  input  logic [ADDR_W-1:0] i_outer_stride,
  output logic              o_addr_valid,
  input  logic              i_addr_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_data_type,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  gen_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        type_q, type_d;
  logic [AccW-1:0]   limit_q, limit_d;
  logic              last_q, last_d, err_q, err_d, zero_q, zero_d;
  logic              init, advance, legal;
  logic [ADDR_W:0]   next_addr;
  logic              next_last;

  glb_addr_loop2d u_loop (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_init         (init),
    .i_advance      (advance),
    .i_base_addr    (i_base_addr),
    .i_inner_cnt    (i_inner_cnt),
    .i_outer_cnt    (i_outer_cnt),
    .i_inner_stride (i_inner_stride),
    .i_outer_stride (i_outer_stride),
    .o_next_addr    (next_addr),
    .o_next_last    (next_last)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      type_q  <= '0;
      limit_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      limit_q <= limit_d;
      last_q  <= last_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    type_d  = type_q;
    limit_d = limit_q;
    last_d  = last_q;
    err_d   = err_q;
    zero_d  = zero_q;
    init    = 1'b0;
    advance = 1'b0;
    // Carry bit set in next_addr always compares above any region limit.
    legal   = (next_addr < limit_q);
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StLoad;
          init    = 1'b1;
          err_d   = 1'b0;
          type_d  = i_data_type;
          zero_d  = (i_inner_cnt == '0) || (i_outer_cnt == '0);
          limit_d = region_limit(i_GLB_allocation, i_data_type);
        end
      end
      StLoad: begin
        if (type_q == DtNone) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else if (zero_q) begin
          state_d = StDone;
        end else if (legal) begin
          state_d = StValid;
          addr_d  = next_addr[ADDR_W-1:0];
          last_d  = next_last;
          advance = 1'b1;
        end else begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StValid: begin
        if (i_addr_ready) begin
          if (last_q) begin
            state_d = StDone;
          end else if (legal) begin
            addr_d  = next_addr[ADDR_W-1:0];
            last_d  = next_last;
            advance = 1'b1;
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_addr_valid = (state_q == StValid);
    o_busy       = (state_q == StLoad) || (state_q == StValid);
    o_done       = (state_q == StDone);
    o_last       = o_addr_valid & last_q;
    o_addr       = addr_q;
    o_data_type  = type_q;
    o_err        = err_q;
  end

endmodule

// File: tb/tb_glb_addr_gen.sv
// Scoreboard bench for glb_addr_gen: expected addresses are queued from a direct
// multiply-based model and popped on every observed handshake.
module tb_glb_addr_gen;
  import glb_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [AllocW-1:0] alloc;
  logic              start;
  logic [1:0]        dtype;
  logic [ADDR_W-1:0] base, icnt, ocnt, istr, ostr;
  logic              addr_valid, addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        out_type;
  logic              last, busy, done, err;

  glb_addr_gen dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_GLB_allocation (alloc),
    .i_start          (start),
    .i_data_type      (dtype),
    .i_base_addr      (base),
    .i_inner_cnt      (icnt),
    .i_outer_cnt      (ocnt),
    .i_inner_stride   (istr),
    .i_outer_stride   (ostr),
    .o_addr_valid     (addr_valid),
    .i_addr_ready     (addr_ready),
    .o_addr           (addr),
    .o_data_type      (out_type),
    .o_last           (last),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned exp_type;
  int          total = 0;
  int          bad = 0;
  int          ready_mode = 0;  // 0: always ready, 1: alternate, 2: never ready

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    addr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: addr_ready = 1'b1;
        1: addr_ready = ~addr_ready;
        default: addr_ready = 1'b0;
      endcase
    end
  end

  // Monitor: consume handshakes and verify stability under backpressure.
  initial begin
    bit          hold;
    logic [31:0] hold_addr;
    logic        hold_last;
    exp_t        e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && addr_valid) begin
        if (hold) begin
          check("hold_addr", 32'(addr), hold_addr);
          check("hold_last", 32'(last), 32'(hold_last));
        end
        if (addr_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_addr", 32'(addr), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("addr", 32'(addr), e.addr);
            check("last", 32'(last), 32'(e.last));
            check("type", 32'(out_type), exp_type);
          end
        end
      end
      hold      = rst_n && addr_valid && !addr_ready;
      hold_addr = 32'(addr);
      hold_last = last;
    end
  end

  task automatic run(input string tag, input int unsigned dt, input int unsigned b,
                     input int unsigned ic, input int unsigned is, input int unsigned oc,
                     input int unsigned os, input int unsigned limit, input int mode,
                     input bit poke);
    bit          exp_err;
    bit          stop;
    int unsigned a;
    int          n;
    int          cycles;
    exp_err = 1'b0;
    stop    = 1'b0;
    n       = 0;
    if (dt == 0) begin
      exp_err = 1'b1;
    end else if (ic != 0 && oc != 0) begin
      for (int o = 0; o < int'(oc); o++) begin
        for (int i = 0; i < int'(ic); i++) begin
          if (!stop) begin
            a = b + o * os + i * is;
            if (a >= limit) begin
              stop    = 1'b1;
              exp_err = 1'b1;
            end else begin
              exp_q.push_back('{addr: a, last: (o == int'(oc) - 1) && (i == int'(ic) - 1)});
              n++;
            end
          end
        end
      end
    end
    exp_type   = dt;
    ready_mode = mode;
    @(posedge clk);
    #1;
    start = 1'b1;
    dtype = 2'(dt);
    base  = ADDR_W'(b);
    icnt  = ADDR_W'(ic);
    ocnt  = ADDR_W'(oc);
    istr  = ADDR_W'(is);
    ostr  = ADDR_W'(os);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_load_busy"}, 32'(busy), 32'd1);
    check({tag, "_load_valid"}, 32'(addr_valid), 32'd0);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (poke && cycles == 2) begin
        start = 1'b1;
        dtype = 2'd3;
        base  = ADDR_W'(500);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (mode == 0) check({tag, "_cycles"}, 32'(cycles), 32'(n + 1));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_err_sticky"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    alloc = {5'd4, 5'd3, 5'd2};  // ifmap 2048, psum 1536, wght 1024 words
    start = 1'b0;
    dtype = '0;
    base  = '0;
    icnt  = '0;
    ocnt  = '0;
    istr  = '0;
    ostr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    rst_n = 1'b1;

    run("basic",   1, 10,   3, 1,  2, 100, 2048, 0, 1'b0);
    run("bp",      1, 10,   3, 1,  2, 100, 2048, 1, 1'b0);
    run("poke",    1, 10,   3, 1,  2, 100, 2048, 0, 1'b1);
    run("bounds",  3, 1020, 8, 1,  1, 0,   1024, 0, 1'b0);
    run("zero",    1, 10,   0, 1,  2, 100, 2048, 0, 1'b0);
    run("type0",   0, 0,    1, 1,  1, 1,   0,    0, 1'b0);
    run("wrap_oob", 2, 1500, 2, 35, 2, 1,   1536, 0, 1'b0);
    run("first_oob", 1, 2048, 1, 1, 1, 1,  2048, 0, 1'b0);

    // Reset while an address is held in VALID.
    ready_mode = 2;
    @(posedge clk);
    #1;
    start = 1'b1;
    dtype = 2'd1;
    base  = ADDR_W'(77);
    icnt  = ADDR_W'(4);
    ocnt  = ADDR_W'(4);
    istr  = ADDR_W'(1);
    ostr  = ADDR_W'(10);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!addr_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rmid_valid", 32'(addr_valid), 32'd1);
    check("rmid_addr", 32'(addr), 32'd77);
    rst_n = 1'b0;
    @(negedge clk);
    check("rmid_o_valid", 32'(addr_valid), 32'd0);
    check("rmid_o_busy", 32'(busy), 32'd0);
    check("rmid_o_done", 32'(done), 32'd0);
    check("rmid_o_err", 32'(err), 32'd0);
    check("rmid_o_last", 32'(last), 32'd0);
    check("rmid_o_addr", 32'(addr), 32'd0);
    check("rmid_o_type", 32'(out_type), 32'd0);
    rst_n = 1'b1;
    run("after_rst", 2, 0, 1, 0, 1, 0, 1536, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
